// File: rtl/dm_arbiter_if.sv
// Bus bundle for dm_arbiter: two requester ports plus the data-memory port.
// slave  = the arbiter's view (requests in, grants/responses and memory strobes out).
// master = the environment's view (requesters and data memory).
interface dm_arbiter_if;
  logic        A_REQ;
  logic        B_REQ;
  logic        A_WRT;
  logic        B_WRT;
  logic [31:0] A_ADDR;
  logic [31:0] B_ADDR;
  logic [31:0] A_WDATA;
  logic [31:0] B_WDATA;
  logic        A_GNT;
  logic        B_GNT;
  logic        A_DONE;
  logic        B_DONE;
  logic [31:0] RDATA;
  logic        ERR;
  logic        DM_READ;
  logic        DM_WRT;
  logic [31:0] DM_ADDR;
  logic [31:0] DM_DIN;
  logic [31:0] DM_DOUT;

  modport slave (
    input  A_REQ, B_REQ, A_WRT, B_WRT, A_ADDR, B_ADDR, A_WDATA, B_WDATA, DM_DOUT,
    output A_GNT, B_GNT, A_DONE, B_DONE, RDATA, ERR,
           DM_READ, DM_WRT, DM_ADDR, DM_DIN
  );

  modport master (
    output A_REQ, B_REQ, A_WRT, B_WRT, A_ADDR, B_ADDR, A_WDATA, B_WDATA, DM_DOUT,
    input  A_GNT, B_GNT, A_DONE, B_DONE, RDATA, ERR,
           DM_READ, DM_WRT, DM_ADDR, DM_DIN
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter giving two requesters access to a single
// data memory. Each access takes three cycles: IDLE (arbitrate and latch),
// ACCESS (grant and drive memory strobe), RESP (done pulse with read data).
module dm_arbiter #(
  parameter int unsigned ADDR_LIMIT = 16384
) (
  input logic        CLK,
  input logic        RST,
  dm_arbiter_if.slave bus
);

  localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        last_b;   // 1 = B was granted most recently
  logic        sel_b;    // requester owning the current transaction
  logic        wrt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        any_req;
  logic        pick_b;
  logic        in_range;
  logic        start;

  assign any_req  = bus.A_REQ | bus.B_REQ;
  // B wins when alone, or on a tie when A was granted last.
  assign pick_b   = bus.B_REQ & (~bus.A_REQ | ~last_b);
  assign in_range = (addr_q < LIMIT);
  assign start    = (state == IDLE) & any_req;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: fixed three-cycle sequence once a request is seen
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the winner's transaction and record the grant on entry to ACCESS
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_b  <= 1'b1;
      sel_b   <= 1'b0;
      wrt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      last_b  <= pick_b;
      sel_b   <= pick_b;
      wrt_q   <= pick_b ? bus.B_WRT   : bus.A_WRT;
      addr_q  <= pick_b ? bus.B_ADDR  : bus.A_ADDR;
      wdata_q <= pick_b ? bus.B_WDATA : bus.A_WDATA;
    end
  end

  // Capture the response at the edge closing ACCESS; RDATA holds otherwise
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (state == ACCESS) begin
      err_q <= ~in_range;
      if (wrt_q || !in_range) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= bus.DM_DOUT;
      end
    end
  end

  // Outputs decoded from state so reset clears them without waiting for CLK
  always_comb begin
    bus.A_GNT   = 1'b0;
    bus.B_GNT   = 1'b0;
    bus.A_DONE  = 1'b0;
    bus.B_DONE  = 1'b0;
    bus.ERR     = 1'b0;
    bus.DM_READ = 1'b0;
    bus.DM_WRT  = 1'b0;
    bus.DM_ADDR = '0;
    bus.DM_DIN  = '0;
    unique case (state)
      ACCESS: begin
        bus.A_GNT   = ~sel_b;
        bus.B_GNT   = sel_b;
        bus.DM_ADDR = addr_q;
        bus.DM_DIN  = wdata_q;
        bus.DM_READ = in_range & ~wrt_q;
        bus.DM_WRT  = in_range & wrt_q;
      end
      RESP: begin
        bus.A_DONE = ~sel_b;
        bus.B_DONE = sel_b;
        bus.ERR    = err_q;
      end
      default: ;
    endcase
  end

  assign bus.RDATA = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level reference model.
module tb_dm_arbiter;

  localparam int unsigned LIM = 64;

  logic CLK;
  logic RST;

  dm_arbiter_if bus ();

  dm_arbiter #(.ADDR_LIMIT(LIM)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Data memory: combinational read, write on the falling edge of the strobe cycle
  logic [31:0] mem [64] = '{default: '0};
  assign bus.DM_DOUT = mem[bus.DM_ADDR[5:0]];
  always @(negedge CLK) begin
    if (bus.DM_WRT) mem[bus.DM_ADDR[5:0]] <= bus.DM_DIN;
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          who_b;
    bit          wrt;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        cur;
  int          age;        // -1 free, 0 = access cycle, 1 = response cycle
  bit          m_last_b;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [64] = '{default: '0};

  int n_checks = 0;
  int n_errors = 0;

  function automatic void model_reset();
    age      = -1;
    m_last_b = 1'b1;
    m_rdata  = '0;
  endfunction

  function automatic void model_edge();
    bit pb;
    if (age == 0) begin
      if (cur.wrt || cur.addr >= LIM) m_rdata = '0;
      else m_rdata = ref_mem[cur.addr[5:0]];
      age = 1;
    end else if (age == 1) begin
      age = -1;
    end else if (bus.A_REQ || bus.B_REQ) begin
      if (bus.A_REQ && bus.B_REQ) pb = !m_last_b;
      else pb = bus.B_REQ;
      cur.who_b = pb;
      cur.wrt   = pb ? bus.B_WRT   : bus.A_WRT;
      cur.addr  = pb ? bus.B_ADDR  : bus.A_ADDR;
      cur.wdata = pb ? bus.B_WDATA : bus.A_WDATA;
      m_last_b  = pb;
      // the memory commits the write during the access cycle itself
      if (cur.wrt && cur.addr < LIM) ref_mem[cur.addr[5:0]] = cur.wdata;
      age = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit acc, rsp, ok;
    acc = (age == 0);
    rsp = (age == 1);
    ok  = (cur.addr < LIM);
    chk("a_gnt",   {31'd0, bus.A_GNT},   {31'd0, acc && !cur.who_b});
    chk("b_gnt",   {31'd0, bus.B_GNT},   {31'd0, acc && cur.who_b});
    chk("a_done",  {31'd0, bus.A_DONE},  {31'd0, rsp && !cur.who_b});
    chk("b_done",  {31'd0, bus.B_DONE},  {31'd0, rsp && cur.who_b});
    chk("err",     {31'd0, bus.ERR},     {31'd0, rsp && !ok});
    chk("dm_read", {31'd0, bus.DM_READ}, {31'd0, acc && ok && !cur.wrt});
    chk("dm_wrt",  {31'd0, bus.DM_WRT},  {31'd0, acc && ok && cur.wrt});
    chk("dm_addr", bus.DM_ADDR, acc ? cur.addr  : 32'd0);
    chk("dm_din",  bus.DM_DIN,  acc ? cur.wdata : 32'd0);
    chk("rdata",   bus.RDATA,   m_rdata);
  endtask

  // one clock: model follows the rising edge, outputs checked on the falling edge
  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask

  task automatic set_a(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.A_REQ = r; bus.A_WRT = w; bus.A_ADDR = a; bus.A_WDATA = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.B_REQ = r; bus.B_WRT = w; bus.B_ADDR = a; bus.B_WDATA = d;
  endtask

  // pulse reset inside the low phase, away from any rising edge
  task automatic pulse_reset();
    #2 RST = 1'b1;
    #1 model_reset();
    check_all();
    #1 RST = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'(LIM);
    if (r == 1) return 32'(LIM - 1);
    if (r == 2) return 32'($urandom_range(65, 100000));
    return 32'($urandom_range(0, 63));
  endfunction

  task automatic drive_rand(input bit is_b, input bit done_now);
    logic r;
    r = is_b ? bus.B_REQ : bus.A_REQ;
    if (r && done_now) r = 1'($urandom_range(0, 1));
    else if (r) r = ($urandom_range(0, 19) != 0);
    else r = ($urandom_range(0, 9) < 4);
    if (is_b) set_b(r, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
    else      set_a(r, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
  endtask

  int order [$];
  int n_adone;
  int n_bdone;

  initial begin
    RST = 1'b1;
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    cur = '{who_b: 1'b0, wrt: 1'b0, addr: '0, wdata: '0};
    model_reset();
    repeat (2) @(negedge CLK);
    check_all();
    #2 RST = 1'b0;

    // write 100 to address 32 from A
    set_a(1'b1, 1'b1, 32'd32, 32'd100);
    tick();
    chk("w_gnt",  {31'd0, bus.A_GNT},  32'd1);
    chk("w_strb", {31'd0, bus.DM_WRT}, 32'd1);
    chk("w_addr", bus.DM_ADDR, 32'd32);
    chk("w_din",  bus.DM_DIN,  32'd100);
    set_a(1'b1, 1'b0, 32'd5, 32'd9);   // changes after grant must not matter
    tick();
    chk("w_done",  {31'd0, bus.A_DONE}, 32'd1);
    chk("w_err",   {31'd0, bus.ERR},    32'd0);
    chk("w_rdata", bus.RDATA, 32'd0);
    set_a(1'b0, 1'b0, '0, '0);
    tick();

    // read it back
    set_a(1'b1, 1'b0, 32'd32, 32'd0);
    tick();
    chk("r_strb", {31'd0, bus.DM_READ}, 32'd1);
    tick();
    chk("r_done",  {31'd0, bus.A_DONE}, 32'd1);
    chk("r_rdata", bus.RDATA, 32'd100);
    set_a(1'b0, 1'b0, '0, '0);
    tick();

    // seed addresses 31 and 33, then tied reads from reset alternate A,B,A,B
    set_a(1'b1, 1'b1, 32'd31, 32'hFFFF_FFFA);
    repeat (2) tick();
    set_a(1'b0, 1'b0, '0, '0);
    tick();
    set_b(1'b1, 1'b1, 32'd33, 32'd5);
    repeat (2) tick();
    set_b(1'b0, 1'b0, '0, '0);
    tick();
    pulse_reset();
    set_a(1'b1, 1'b0, 32'd31, 32'd0);
    set_b(1'b1, 1'b0, 32'd33, 32'd0);
    n_adone = 0;
    n_bdone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.A_GNT) order.push_back(0);
      if (bus.B_GNT) order.push_back(1);
      if (bus.A_DONE) begin n_adone++; chk("rr_rdata_a", bus.RDATA, 32'hFFFF_FFFA); end
      if (bus.B_DONE) begin n_bdone++; chk("rr_rdata_b", bus.RDATA, 32'd5); end
    end
    chk("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk("rr_order", 32'(order[i]), 32'(i % 2));
    chk("rr_adone", 32'(n_adone), 32'd2);
    chk("rr_bdone", 32'(n_bdone), 32'd2);
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    repeat (2) tick();

    // out-of-range read from B
    set_b(1'b1, 1'b0, 32'd20000, 32'd0);
    tick();
    chk("oor_gnt",  {31'd0, bus.B_GNT},   32'd1);
    chk("oor_rd",   {31'd0, bus.DM_READ}, 32'd0);
    chk("oor_wr",   {31'd0, bus.DM_WRT},  32'd0);
    tick();
    chk("oor_done",  {31'd0, bus.B_DONE}, 32'd1);
    chk("oor_err",   {31'd0, bus.ERR},    32'd1);
    chk("oor_rdata", bus.RDATA, 32'd0);
    set_b(1'b0, 1'b0, '0, '0);
    tick();

    // reset in the middle of a write access
    set_a(1'b1, 1'b1, 32'd10, 32'd7);
    tick();
    chk("rst_wrt_before", {31'd0, bus.DM_WRT}, 32'd1);
    set_a(1'b0, 1'b0, '0, '0);
    #2 RST = 1'b1;
    #1;
    chk("rst_wrt_drop", {31'd0, bus.DM_WRT}, 32'd0);
    chk("rst_gnt_drop", {31'd0, bus.A_GNT},  32'd0);
    model_reset();
    #1 RST = 1'b0;
    tick();
    chk("rst_no_done", {31'd0, bus.A_DONE}, 32'd0);
    set_a(1'b1, 1'b0, 32'd1, 32'd0);
    set_b(1'b1, 1'b0, 32'd2, 32'd0);
    tick();
    chk("rst_tie_a", {31'd0, bus.A_GNT}, 32'd1);
    chk("rst_tie_b", {31'd0, bus.B_GNT}, 32'd0);
    tick();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    tick();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      drive_rand(1'b0, (age == 1) && !cur.who_b);
      drive_rand(1'b1, (age == 1) && cur.who_b);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 16384, meaning the number of valid word addresses; any address >= ADDR_LIMIT is out of range.
REQ-002 SHALL have port CLK  input  1  the single clock; all state SHALL update on posedge CLK.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports A_REQ / B_REQ  input  1  access request from requester A or B; the requester holds it high until its DONE.
REQ-005 SHALL have ports A_WRT / B_WRT  input  1  1 = write, 0 = read; qualified by REQ.
REQ-006 SHALL have ports A_ADDR / B_ADDR  input  32  word address.
REQ-007 SHALL have ports A_WDATA / B_WDATA  input  32  write data.
REQ-008 SHALL have ports A_GNT / B_GNT  output  1  high for the ACCESS cycle of that requester.
REQ-009 SHALL have ports A_DONE / B_DONE  output  1  one-cycle completion pulse.
REQ-010 SHALL have port RDATA  output  32  registered read data, shared, valid while a DONE is high.
REQ-011 SHALL have port ERR  output  1  high with DONE when the address was out of range.
REQ-012 SHALL have ports DM_READ, DM_WRT  output  1  strobes to data memory.
REQ-013 SHALL have ports DM_ADDR, DM_DIN  output  32  address and write data to data memory.
REQ-014 SHALL have port DM_DOUT  input  32  combinational read data from data memory.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any REQ is sampled high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-016 SHALL, in IDLE, latch the winner's WRT, ADDR, WDATA into internal registers at the grant edge; later input changes SHALL NOT affect the transaction.
REQ-017 SHALL arbitrate round-robin: single requester wins; both requesting -> the requester not granted last wins; after reset A wins the first tie.
REQ-018 SHALL update the last-granted record only on entry to ACCESS.
REQ-019 SHALL, in ACCESS, drive DM_ADDR/DM_DIN from the latched registers and assert exactly one of DM_READ (read) or DM_WRT (write) for the whole cycle, so the memory's negedge write sees a stable strobe.
REQ-020 SHALL assert neither DM strobe outside ACCESS; DM_ADDR and DM_DIN SHALL be 0 outside ACCESS.
REQ-021 SHALL capture DM_DOUT into RDATA at the posedge ending ACCESS for reads; RDATA SHALL be 0 after writes and errors and hold its value otherwise.
REQ-022 SHALL, in RESP, pulse the granted requester's DONE for exactly one cycle; the other DONE SHALL stay 0.
REQ-023 Latency SHALL be fixed: REQ sampled at edge N -> GNT during cycle N..N+1 -> DONE during cycle N+1..N+2; no back-to-back grant, so each access occupies 3 cycles including IDLE.
REQ-024 SHALL, for latched address >= ADDR_LIMIT, assert GNT but no DM strobe in ACCESS, then DONE with ERR=1 and RDATA=0.
REQ-025 SHALL ignore REQ deassertion during ACCESS or RESP; the latched transaction completes and DONE still pulses.
REQ-026 SHALL treat a REQ still high in IDLE after DONE as a new request.

Reset
REQ-027 SHALL, while RST is high, force state IDLE, last-granted = B, all GNT/DONE/ERR/DM_READ/DM_WRT = 0, RDATA/DM_ADDR/DM_DIN = 0, immediately and independently of CLK.
REQ-028 SHALL, on reset during ACCESS, drop DM strobes immediately; the aborted transaction SHALL produce no DONE.

Verification
REQ-029 A write addr 32 data 100, B idle -> A_GNT + DM_WRT one cycle, DM_ADDR=32, DM_DIN=100; A_DONE next cycle, ERR=0, RDATA=0.
REQ-030 A read addr 32 after above -> DM_READ in ACCESS, A_DONE with RDATA=100.
REQ-031 A and B request reads (addrs 31, 33) continuously from reset -> grant order A,B,A,B; RDATA=-6 with A_DONE, 5 with B_DONE.
REQ-032 B read addr 20000 -> B_GNT, no DM strobe, B_DONE with ERR=1, RDATA=0.
REQ-033 A write in ACCESS, RST pulsed mid-cycle -> DM_WRT falls with RST, no A_DONE; after release, tied A/B requests grant A first.
